insert0_sched: RTL and testbench



---
 rtl/insert0_sched_pkg.sv | 24 ++
 rtl/insert0_rr_arb.sv | 69 ++++++
 rtl/insert0_sched.sv | 159 +++++++++++++++
 tb/tb_insert0_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/insert0_sched_pkg.sv
// Shared types and helpers for the zero-insertion frame scheduler.
// Optional build macro INSERT0_SCHED_PRIO_EN is consumed by the arbiter and top.
package insert0_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Wide enough for 9*511 + 32 = 4631 with headroom.
  localparam int CNT_W = 15;

  // Frame timer load value: 9 cycles per byte (worst-case stuffing) plus tail,
  // minus one because the RUN state exits when the counter reaches zero.
  function automatic logic [CNT_W-1:0] frame_cycles(input logic [CNT_W-1:0] len,
                                                    input int tail);
    logic [31:0] total;
    total = 32'(len) * 32'd9 + 32'(tail) - 32'd1;
    return total[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/insert0_rr_arb.sv
// Combinational round-robin arbiter for the frame scheduler.
// With INSERT0_SCHED_PRIO_EN defined, requester 0 has strict priority and the
// rotation covers only requesters 1..NREQ-1 (a pointer of 0 starts at 1).
module insert0_rr_arb
  import insert0_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] win_idx,
  output logic             valid
);

  int               idx;
  logic [PTR_W-1:0] sel;
`ifdef INSERT0_SCHED_PRIO_EN
  int               start;
`endif

  // Scan requesters starting at ptr and take the first asserted one.
`ifdef INSERT0_SCHED_PRIO_EN
  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    sel     = '0;
    start   = 1;
    if (req[0]) begin
      valid  = 1'b1;
      win[0] = 1'b1;
    end else begin
      start = (ptr == '0) ? 1 : int'(ptr);
      for (int off = 0; off < NREQ - 1; off++) begin
        idx = start + off;
        if (idx >= NREQ) idx = idx - (NREQ - 1);
        sel = PTR_W'(idx);
        if (!valid && req[sel]) begin
          valid    = 1'b1;
          win_idx  = sel;
          win[sel] = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (!valid && req[sel]) begin
        valid    = 1'b1;
        win_idx  = sel;
        win[sel] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/insert0_sched.sv
// Frame scheduler for the zero-insertion datapath: arbitrates requesters,
// times each frame, pulses the datapath clear and enforces an inter-frame gap.
// Optional build macro INSERT0_SCHED_PRIO_EN gives requester 0 strict priority.
module insert0_sched
  import insert0_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 10,
  parameter int MAX_LEN  = 511,
  parameter int TAIL_CYC = 32,
  parameter int GAP_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic                  trastart_flag,
  output logic [LEN_W-1:0]      db,
  output logic                  inr
);

  localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [PTR_W-1:0]   ptr, ptr_d, next_ptr;
  logic [NREQ-1:0]    req_q;
  logic [NREQ-1:0]    arb_win;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [LEN_W-1:0]   arb_len;
  logic               len_bad;
  logic [NREQ-1:0]    grant_d;
  logic               done_d, err_d, trastart_d, inr_d;
  logic [LEN_W-1:0]   db_d;

  // Arbitration works on the registered request vector.
  insert0_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (req_q),
    .ptr     (ptr),
    .win     (arb_win),
    .win_idx (arb_idx),
    .valid   (arb_valid)
  );

  // Select the winner's length and judge whether the frame is legal.
  always_comb begin
    arb_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PTR_W'(i)) arb_len = req_len[i*LEN_W +: LEN_W];
    end
    len_bad = (arb_len == '0) || (32'(arb_len) > 32'(MAX_LEN));
  end

  // Rotate the pointer past the winner; a priority win leaves the rotation alone.
  always_comb begin
`ifdef INSERT0_SCHED_PRIO_EN
    if (arb_idx == '0)                    next_ptr = ptr;
    else if (arb_idx == PTR_W'(NREQ - 1)) next_ptr = PTR_W'(1);
    else                                  next_ptr = arb_idx + PTR_W'(1);
`else
    if (arb_idx == PTR_W'(NREQ - 1)) next_ptr = '0;
    else                             next_ptr = arb_idx + PTR_W'(1);
`endif
  end

  // Next-state and next-output logic; the cycle after any done pulse is skipped
  // by the arbiter so a rejected requester has time to drop its request.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ptr_d      = ptr;
    grant_d    = grant;
    done_d     = 1'b0;
    err_d      = 1'b0;
    trastart_d = trastart_flag;
    db_d       = db;
    inr_d      = 1'b0;
    case (state)
      IDLE: begin
        grant_d    = '0;
        trastart_d = 1'b0;
        if (arb_valid && !done) begin
          ptr_d   = next_ptr;
          grant_d = arb_win;
          if (len_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d    = RUN;
            trastart_d = 1'b1;
            db_d       = arb_len;
            cnt_d      = frame_cycles(CNT_W'(arb_len), TAIL_CYC);
          end
        end
      end
      RUN: begin
        if (abort || (cnt == '0)) begin
          state_d    = DRAIN;
          trastart_d = 1'b0;
          inr_d      = 1'b1;
          done_d     = 1'b1;
          err_d      = abort;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d = GAP;
        grant_d = '0;
        cnt_d   = CNT_W'(GAP_EFF - 1);
      end
      GAP: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= '0;
      req_q         <= '0;
      grant         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      trastart_flag <= 1'b0;
      db            <= '0;
      inr           <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ptr           <= ptr_d;
      req_q         <= req;
      grant         <= grant_d;
      done          <= done_d;
      err           <= err_d;
      busy          <= (state_d != IDLE);
      trastart_flag <= trastart_d;
      db            <= db_d;
      inr           <= inr_d;
    end
  end

endmodule

// File: tb/tb_insert0_sched.sv
// Directed self-checking bench for insert0_sched (NREQ=4, LEN_W=10).
// Expected grant orders follow INSERT0_SCHED_PRIO_EN when it is defined.
module tb_insert0_sched;

  localparam int NREQ  = 4;
  localparam int LEN_W = 10;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic                  abort;
  logic [NREQ-1:0]       grant;
  logic                  done;
  logic                  err;
  logic                  busy;
  logic                  trastart_flag;
  logic [LEN_W-1:0]      db;
  logic                  inr;

  int vectors     = 0;
  int miscompares = 0;
  int n;
  logic [3:0] rr_exp [6];

  insert0_sched #(
    .NREQ     (NREQ),
    .LEN_W    (LEN_W),
    .MAX_LEN  (511),
    .TAIL_CYC (32),
    .GAP_CYC  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_len       (req_len),
    .abort         (abort),
    .grant         (grant),
    .done          (done),
    .err           (err),
    .busy          (busy),
    .trastart_flag (trastart_flag),
    .db            (db),
    .inr           (inr)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input int l0, input int l1,
                               input int l2, input int l3, input logic ab);
    req     = r;
    req_len = {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
    abort   = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sigVal(input int which);
    case (which)
      0:       return trastart_flag;
      1:       return !trastart_flag;
      2:       return !busy;
      default: return busy;
    endcase
  endfunction

  task automatic waitFor(input string tag, input int which, input int limit);
    int k;
    k = 0;
    while (!sigVal(which) && k < limit) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(sigVal(which)), 32'd1);
  endtask

  task automatic countWhile(input int which, input int limit, output int cnt_out);
    cnt_out = 0;
    while (sigVal(which) && cnt_out < limit) begin
      cnt_out++;
      tick();
    end
  endtask

  task automatic rejectCase(input string tag, input int len);
    applyStimulus(4'b0100, 0, 0, len, 0, 1'b0);
    tick();
    tick();
    checkOutput({tag, "_done_err"}, 32'({done, err}), 32'h3);
    checkOutput({tag, "_grant"}, 32'(grant), 32'h4);
    checkOutput({tag, "_no_datapath"}, 32'({trastart_flag, inr, busy}), 32'h0);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    checkOutput({tag, "_pulse_end"}, 32'({done, err, grant}), 32'h0);
  endtask

  initial begin
`ifdef INSERT0_SCHED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
`endif
    rst_n = 1'b1;
    applyStimulus(4'b0000, 0, 0, 0, 0, 1'b0);
    #3 rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_ctrl", 32'({done, err, busy, trastart_flag, inr}), 32'h0);
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_db", 32'(db), 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // Round-robin with requesters 0,1,3 held; last frame has its request dropped mid-run.
    applyStimulus(4'b1011, 3, 3, 3, 3, 1'b0);
    for (int f = 0; f < 6; f++) begin
      waitFor("rr_start", 0, 200);
      checkOutput("rr_grant", 32'(grant), 32'(rr_exp[f]));
      if (f == 5) applyStimulus(4'b0000, 3, 3, 3, 3, 1'b0);
      waitFor("rr_end", 1, 200);
      checkOutput("rr_done", 32'(done), 32'h1);
    end
    waitFor("rr_idle", 2, 50);

    // Single frame: requester 1, length 10.
    applyStimulus(4'b0010, 0, 10, 0, 0, 1'b0);
    tick();
    checkOutput("sf_latency", 32'(trastart_flag), 32'h0);
    tick();
    checkOutput("sf_start", 32'(trastart_flag), 32'h1);
    checkOutput("sf_grant", 32'(grant), 32'h2);
    checkOutput("sf_db", 32'(db), 32'd10);
    checkOutput("sf_busy", 32'(busy), 32'h1);
    countWhile(0, 6000, n);
    checkOutput("sf_run_cycles", 32'(n), 32'd122);
    checkOutput("sf_drain", 32'({inr, done, err}), 32'h6);
    checkOutput("sf_drain_grant", 32'(grant), 32'h2);
    applyStimulus(4'b0000, 0, 10, 0, 0, 1'b0);
    tick();
    checkOutput("sf_gap_ctrl", 32'({inr, done, trastart_flag, grant}), 32'h0);
    checkOutput("sf_gap_db", 32'(db), 32'd10);
    countWhile(3, 50, n);
    checkOutput("sf_gap_cycles", 32'(n), 32'd4);

    // Rejected lengths.
    rejectCase("rej_len0", 0);
    rejectCase("rej_len600", 600);

    // Abort 20 cycles into a length-50 frame.
    applyStimulus(4'b0010, 0, 50, 0, 0, 1'b0);
    tick();
    tick();
    checkOutput("ab_start", 32'(trastart_flag), 32'h1);
    repeat (19) tick();
    checkOutput("ab_still_run", 32'(trastart_flag), 32'h1);
    applyStimulus(4'b0010, 0, 50, 0, 0, 1'b1);
    tick();
    checkOutput("ab_drain", 32'({trastart_flag, inr, done, err}), 32'h7);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    checkOutput("ab_gap", 32'({busy, inr, done}), 32'h4);
    waitFor("ab_idle", 2, 20);

    // Longest legal frame.
    applyStimulus(4'b0001, 511, 0, 0, 0, 1'b0);
    waitFor("max_start", 0, 10);
    checkOutput("max_db", 32'(db), 32'd511);
    countWhile(0, 6000, n);
    checkOutput("max_run_cycles", 32'(n), 32'd4631);
    checkOutput("max_drain", 32'({done, err}), 32'h2);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1'b0);
    waitFor("max_idle", 2, 20);

    // Abort on the final RUN cycle of a length-1 frame (41 RUN cycles).
    applyStimulus(4'b0001, 1, 0, 0, 0, 1'b0);
    waitFor("co_start", 0, 10);
    repeat (40) tick();
    checkOutput("co_last_run", 32'(trastart_flag), 32'h1);
    applyStimulus(4'b0001, 1, 0, 0, 0, 1'b1);
    tick();
    checkOutput("co_drain", 32'({trastart_flag, done, err}), 32'h3);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1'b0);
    waitFor("co_idle", 2, 20);

    // Reset in the middle of a frame, then check the pointer restarted at 0.
    applyStimulus(4'b0010, 0, 20, 0, 0, 1'b0);
    waitFor("rst_start", 0, 10);
    repeat (29) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_ctrl", 32'({done, err, busy, trastart_flag, inr}), 32'h0);
    checkOutput("rst_async_grant", 32'(grant), 32'h0);
    checkOutput("rst_async_db", 32'(db), 32'h0);
    applyStimulus(4'b1111, 5, 5, 5, 5, 1'b0);
    #2 rst_n = 1'b1;
    waitFor("rst_post_start", 0, 10);
    checkOutput("rst_post_grant", 32'(grant), 32'h1);
    applyStimulus(4'b0000, 0, 0, 0, 0, 1'b0);
    waitFor("rst_post_idle", 2, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
